// File: rtl/scan_pattern_sched_if.sv
// Bus bundle for scan_pattern_sched: run control, ADPLL/capture handshake inputs and
// scan control outputs. The design takes the slave side, the driver takes master.
interface scan_pattern_sched_if #(
   parameter int CNT_W = 20,
   parameter int PAT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] scan_num;
   logic [PAT_W-1:0] pat_num;
   logic             adpll_lock;
   logic             cap_ack;
   logic             shift_en;
   logic             scan_clk;
   logic             test_se;
   logic             cap_req;
   logic             sub_rst;
   logic             busy;
   logic             scan_done;
   logic [1:0]       err;
   logic [PAT_W-1:0] pat_cnt;

   modport slave (
      input  start, scan_num, pat_num, adpll_lock, cap_ack,
      output shift_en, scan_clk, test_se, cap_req, sub_rst, busy, scan_done, err, pat_cnt
   );
   modport master (
      output start, scan_num, pat_num, adpll_lock, cap_ack,
      input  shift_en, scan_clk, test_se, cap_req, sub_rst, busy, scan_done, err, pat_cnt
   );
endinterface

// File: rtl/scan_pattern_sched.sv
// Multi-pattern scan sequencer: lock wait, sub-block reset, shift/capture loop, unload.
// Optional SCAN_RETRY_EN: lock loss while scanning re-locks and retries the pattern (3 times).
module scan_pattern_sched #(
   parameter int CNT_W       = 20,
   parameter int PAT_W       = 8,
   parameter int CLK_DIV     = 2,
   parameter int LOCK_WAIT   = 16,
   parameter int SUB_RST_CYC = 4,
   parameter int CAP_TMO     = 64
) (
   input logic                 clk,
   input logic                 rst,
   scan_pattern_sched_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOCK   = 3'd1;
   localparam logic [2:0] S_SUBRST = 3'd2;
   localparam logic [2:0] S_SHIFT  = 3'd3;
   localparam logic [2:0] S_CAP    = 3'd4;
   localparam logic [2:0] S_UNLOAD = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;
   localparam logic [2:0] S_ERR    = 3'd7;

   localparam int LK_W = $clog2(LOCK_WAIT + 1);
   localparam int SR_W = $clog2(SUB_RST_CYC + 1);
   localparam int DV_W = $clog2(2 * CLK_DIV);
   localparam int TM_W = $clog2(CAP_TMO + 1);

   localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(LOCK_WAIT - 1);
   localparam logic [SR_W-1:0] SUB_LAST  = SR_W'(SUB_RST_CYC - 1);
   localparam logic [DV_W-1:0] DIV_HALF  = DV_W'(CLK_DIV);
   localparam logic [DV_W-1:0] DIV_LAST  = DV_W'(2 * CLK_DIV - 1);
   localparam logic [TM_W-1:0] TMO_LAST  = TM_W'(CAP_TMO - 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] sn_q, bit_cnt;
   logic [PAT_W-1:0] pn_q, pat_cnt_q, pat_nxt;
   logic [1:0]       err_q;
   logic [LK_W-1:0]  lock_cnt;
   logic [SR_W-1:0]  sub_cnt;
   logic [DV_W-1:0]  div_cnt;
   logic [TM_W-1:0]  tmo_cnt;
   logic             cap_ph;
   logic             running, shifting, div_last, shift_last;
`ifdef SCAN_RETRY_EN
   logic [1:0]       retry_cnt;
   logic             retry_ok;
   assign retry_ok = (state != S_SUBRST) && (retry_cnt != 2'd3);
`endif

   assign running    = (state == S_SUBRST) || (state == S_SHIFT) ||
                       (state == S_CAP) || (state == S_UNLOAD);
   assign shifting   = (state == S_SHIFT) || (state == S_UNLOAD);
   assign div_last   = (div_cnt == DIV_LAST);
   // Leave on the falling edge that completes the last bit; an empty chain leaves at once.
   assign shift_last = (sn_q == '0) || (div_last && (bit_cnt == sn_q - 1'b1));
   assign pat_nxt    = pat_cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         sn_q      <= '0;
         pn_q      <= '0;
         pat_cnt_q <= '0;
         err_q     <= '0;
         lock_cnt  <= '0;
         sub_cnt   <= '0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         tmo_cnt   <= '0;
         cap_ph    <= 1'b0;
`ifdef SCAN_RETRY_EN
         retry_cnt <= '0;
`endif
      end else if (running && !bus.adpll_lock) begin
         // Lock loss beats everything else, including a same-cycle cap_ack.
`ifdef SCAN_RETRY_EN
         if (retry_ok) begin
            state     <= S_LOCK;
            lock_cnt  <= '0;
            retry_cnt <= retry_cnt + 1'b1;
         end else
`endif
         begin
            state <= S_ERR;
            err_q <= 2'b01;
         end
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: if (bus.start) begin
               state     <= S_LOCK;
               sn_q      <= bus.scan_num;
               pn_q      <= bus.pat_num;
               pat_cnt_q <= '0;
               err_q     <= '0;
               lock_cnt  <= '0;
`ifdef SCAN_RETRY_EN
               retry_cnt <= '0;
`endif
            end
            S_LOCK: begin
               if (!bus.adpll_lock) lock_cnt <= '0;
               else if (lock_cnt == LOCK_LAST) begin
                  state   <= S_SUBRST;
                  sub_cnt <= '0;
               end else lock_cnt <= lock_cnt + 1'b1;
            end
            S_SUBRST: begin
               if (sub_cnt == SUB_LAST) begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  if (pn_q == '0)             state <= S_DONE;
                  else if (pat_cnt_q == pn_q) state <= S_UNLOAD;
                  else                        state <= S_SHIFT;
               end else sub_cnt <= sub_cnt + 1'b1;
            end
            S_SHIFT, S_UNLOAD: begin
               if (shift_last) begin
                  state   <= (state == S_SHIFT) ? S_CAP : S_DONE;
                  cap_ph  <= 1'b0;
                  tmo_cnt <= '0;
               end else begin
                  div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                  if (div_last) bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_CAP: begin
               // First cycle is SE settle with cap_req low; acks there are not accepted.
               if (!cap_ph) cap_ph <= 1'b1;
               else if (bus.cap_ack) begin
                  pat_cnt_q <= pat_nxt;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  state     <= (pat_nxt < pn_q) ? S_SHIFT : S_UNLOAD;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= S_ERR;
                  err_q <= 2'b10;
               end else tmo_cnt <= tmo_cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.shift_en  = shifting;
   assign bus.test_se   = shifting;
   assign bus.scan_clk  = shifting && (div_cnt >= DIV_HALF);
   assign bus.cap_req   = (state == S_CAP) && cap_ph;
   assign bus.sub_rst   = (state == S_SUBRST);
   assign bus.busy      = running || (state == S_LOCK);
   assign bus.scan_done = (state == S_DONE);
   assign bus.err       = err_q;
   assign bus.pat_cnt   = pat_cnt_q;
endmodule

// File: tb/tb_scan_pattern_sched.sv
// Self-checking bench for scan_pattern_sched: phase/elapsed-time reference model compared
// every cycle, plus hand-computed scenario expectations.
module tb_scan_pattern_sched;
   localparam int CNT_W = 20, PAT_W = 8, CLK_DIV = 2, LOCK_WAIT = 16, SUB_RST_CYC = 4, CAP_TMO = 64;
   localparam int P_IDLE = 0, P_LOCK = 1, P_SUB = 2, P_SHIFT = 3, P_CAP = 4, P_UNL = 5,
                  P_DONE = 6, P_ERR = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;

   scan_pattern_sched_if #(.CNT_W(CNT_W), .PAT_W(PAT_W)) bus();

   scan_pattern_sched #(
      .CNT_W(CNT_W), .PAT_W(PAT_W), .CLK_DIV(CLK_DIV), .LOCK_WAIT(LOCK_WAIT),
      .SUB_RST_CYC(SUB_RST_CYC), .CAP_TMO(CAP_TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: current phase, cycles spent in it, and run bookkeeping.
   int mph = P_IDLE, mt = 0, mlock = 0, mpat = 0, merr = 0, msn = 0, mpn = 0;
`ifdef SCAN_RETRY_EN
   int mretry = 0;
`endif
   int ack_dly = 3, drop_rate = 0, rst_rate = 0;
   bit stray = 1'b0;
   int n_chk = 0, n_pass = 0;
   int sclk_rise = 0, creq_rise = 0, creq_hi = 0, sub_hi = 0, shen_hi = 0;
   logic p_sclk = 1'b0, p_creq = 1'b0;

   task automatic mstep(input bit st, input bit lk, input bit ack, input bit r);
      int nph, len;
      if (r) begin
         mph = P_IDLE; mt = 0; mpat = 0; merr = 0; mlock = 0;
         return;
      end
      nph = mph;
      len = (msn == 0) ? 1 : msn * 2 * CLK_DIV;
      if ((mph inside {P_SUB, P_SHIFT, P_CAP, P_UNL}) && !lk) begin
`ifdef SCAN_RETRY_EN
         if (mph != P_SUB && mretry < 3) begin mretry++; nph = P_LOCK; mlock = 0; end
         else begin nph = P_ERR; merr = 1; end
`else
         nph = P_ERR; merr = 1;
`endif
      end else begin
         case (mph)
            P_IDLE, P_DONE, P_ERR: if (st) begin
               nph = P_LOCK; msn = int'(bus.scan_num); mpn = int'(bus.pat_num);
               mpat = 0; merr = 0; mlock = 0;
`ifdef SCAN_RETRY_EN
               mretry = 0;
`endif
            end
            P_LOCK: begin
               mlock = lk ? mlock + 1 : 0;
               if (mlock == LOCK_WAIT) begin nph = P_SUB; mlock = 0; end
            end
            P_SUB:   if (mt == SUB_RST_CYC - 1)
                        nph = (mpn == 0) ? P_DONE : (mpat >= mpn) ? P_UNL : P_SHIFT;
            P_SHIFT: if (mt == len - 1) nph = P_CAP;
            P_UNL:   if (mt == len - 1) nph = P_DONE;
            P_CAP: begin
               if (mt >= 1 && ack) begin mpat++; nph = (mpat < mpn) ? P_SHIFT : P_UNL; end
               else if (mt == CAP_TMO) begin nph = P_ERR; merr = 2; end
            end
            default: ;
         endcase
      end
      mt = (nph != mph) ? 0 : mt + 1;
      mph = nph;
   endtask

   function automatic logic [16:0] dut_vec();
      return {bus.shift_en, bus.scan_clk, bus.test_se, bus.cap_req, bus.sub_rst,
              bus.busy, bus.scan_done, bus.err, bus.pat_cnt};
   endfunction

   function automatic logic [16:0] exp_vec();
      logic sh;
      logic [1:0] e;
      logic [7:0] pc;
      sh = (mph == P_SHIFT) || (mph == P_UNL);
      e  = 2'(merr);
      pc = 8'(mpat);
      return {sh, sh && ((mt / CLK_DIV) % 2 == 1), sh, (mph == P_CAP) && (mt >= 1),
              mph == P_SUB, mph inside {P_LOCK, P_SUB, P_SHIFT, P_CAP, P_UNL},
              mph == P_DONE, e, pc};
   endfunction

   task automatic check();
      logic [16:0] d, e;
      d = dut_vec();
      e = exp_vec();
      n_chk++;
      if (d === e) n_pass++;
      else $display("FAIL cycle_model t=%0t dut=%b exp=%b phase=%0d t_in_phase=%0d",
                    $time, d, e, mph, mt);
      if (bus.scan_clk && !p_sclk) sclk_rise++;
      if (bus.cap_req && !p_creq) creq_rise++;
      if (bus.cap_req) creq_hi++;
      if (bus.sub_rst) sub_hi++;
      if (bus.shift_en) shen_hi++;
      p_sclk = bus.scan_clk;
      p_creq = bus.cap_req;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
   endtask

   task automatic cyc();
      bus.cap_ack = ((mph == P_CAP) && ack_dly >= 0 && mt == ack_dly + 1) ||
                    (stray && mph != P_CAP && $urandom_range(0, 15) == 0);
      @(posedge clk);
      mstep(bus.start, bus.adpll_lock, bus.cap_ack, rst);
      @(negedge clk);
      check();
   endtask

   task automatic clr_obs();
      sclk_rise = 0; creq_rise = 0; creq_hi = 0; sub_hi = 0; shen_hi = 0;
   endtask

   task automatic go(input int sn, input int pn);
      bus.scan_num = CNT_W'(sn);
      bus.pat_num  = PAT_W'(pn);
      bus.start    = 1'b1;
      cyc();
      bus.start    = 1'b0;
   endtask

   task automatic run_until(input int budget);
      int n;
      n = 0;
      while ((mph inside {P_LOCK, P_SUB, P_SHIFT, P_CAP, P_UNL}) && n < budget) begin
         if (drop_rate > 0) begin
            bus.adpll_lock = ($urandom_range(0, drop_rate - 1) != 0);
            bus.start      = ($urandom_range(0, 40) == 0);
            bus.scan_num   = CNT_W'($urandom_range(0, 7));
            bus.pat_num    = PAT_W'($urandom_range(0, 5));
         end
         if (rst_rate > 0 && $urandom_range(0, rst_rate - 1) == 0) rst = 1'b1;
         cyc();
         rst = 1'b0;
         bus.start = 1'b0;
         n++;
      end
      chk("run_bounded", int'(n < budget), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.start = 1'b0; bus.scan_num = '0; bus.pat_num = '0;
      bus.adpll_lock = 1'b0; bus.cap_ack = 1'b0;
      rst = 1'b1;
      repeat (3) cyc();
      chk("reset_outputs", int'(dut_vec()), 0);
      rst = 1'b0;
      cyc();

      // T1: 5-bit chain, 2 patterns, ack 3 cycles after request.
      bus.adpll_lock = 1'b1; ack_dly = 3; clr_obs();
      go(5, 2);
      run_until(2000);
      chk("t1_scan_clk_rises", sclk_rise, 15);
      chk("t1_cap_req_pulses", creq_rise, 2);
      chk("t1_pat_cnt", int'(bus.pat_cnt), 2);
      chk("t1_scan_done", int'(bus.scan_done), 1);
      chk("t1_err", int'(bus.err), 0);

      // T2: lock glitch 10 cycles into lock wait restarts the count.
      bus.adpll_lock = 1'b0; clr_obs();
      go(2, 1);
      bus.adpll_lock = 1'b1;
      repeat (10) cyc();
      bus.adpll_lock = 1'b0;
      cyc();
      bus.adpll_lock = 1'b1;
      n = 0;
      while (!bus.sub_rst && n < 100) begin cyc(); n++; end
      chk("t2_lock_to_subrst", n, 16);
      run_until(2000);
      chk("t2_sub_rst_width", sub_hi, 4);

      // T3: lock drops mid-shift of the first pattern, then a fresh run.
      ack_dly = 2;
      go(5, 2);
      n = 0;
      while (!(mph == P_SHIFT && mt == 7) && n < 200) begin cyc(); n++; end
      chk("t3_reached_shift", int'(bus.shift_en), 1);
      bus.adpll_lock = 1'b0;
      cyc();
`ifndef SCAN_RETRY_EN
      chk("t3_err_lock", int'(bus.err), 1);
      chk("t3_scan_clk_low", int'(bus.scan_clk), 0);
      chk("t3_test_se_low", int'(bus.test_se), 0);
`endif
      bus.adpll_lock = 1'b1;
      go(3, 1);
      chk("t3_restart_pat_cnt", int'(bus.pat_cnt), 0);
      chk("t3_restart_busy", int'(bus.busy), 1);
      run_until(2000);

      // T4: capture acknowledge never arrives.
      ack_dly = -1; clr_obs();
      go(2, 1);
      run_until(2000);
      chk("t4_cap_req_cycles", creq_hi, 64);
      chk("t4_err_timeout", int'(bus.err), 2);

      // T5: empty chain with 3 patterns, then zero patterns.
      ack_dly = 1; clr_obs();
      go(0, 3);
      run_until(2000);
      chk("t5_no_scan_clk", sclk_rise, 0);
      chk("t5_pat_cnt", int'(bus.pat_cnt), 3);
      chk("t5_done", int'(bus.scan_done), 1);
      clr_obs();
      go(0, 0);
      run_until(2000);
      chk("t5_zero_pat_no_shift", shen_hi, 0);
      chk("t5_zero_pat_done", int'(bus.scan_done), 1);

      // Reset in the middle of a run.
      ack_dly = 2;
      go(4, 2);
      repeat (30) cyc();
      rst = 1'b1;
      cyc();
      chk("midrun_reset_outputs", int'(dut_vec()), 0);
      rst = 1'b0;
      cyc();

      // Randomised runs: lock drops, stray acks, timeouts, resets, ignored starts.
      stray = 1'b1; drop_rate = 250; rst_rate = 700;
      for (int r = 0; r < 30; r++) begin
         ack_dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
         bus.adpll_lock = 1'b1;
         go(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
         run_until(4000);
         repeat ($urandom_range(0, 3)) cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
